// File: rtl/dir_input_conditioner.sv
// Four-button direction front end: synchronise, debounce, decode single presses into
// 3-bit codes with chord rejection. Optional auto-repeat is enabled by AUTO_REPEAT_EN.
module dir_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  output logic [2:0] dir_out,
  output logic       dir_valid,
  output logic       multi_err,
  output logic       btn_busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 4; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

  function automatic logic [2:0] encode_dir(input logic [3:0] onehot);
    logic [2:0] code;
    case (onehot)
      4'b0001: code = 3'b000;
      4'b0010: code = 3'b001;
      4'b0100: code = 3'b010;
      4'b1000: code = 3'b011;
      default: code = 3'b111;
    endcase
    return code;
  endfunction

  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       stable_r;
  logic [3:0]       stable_s;
  logic [3:0]       stable_d_r;
  logic [CNT_W-1:0] db_cnt_r [4];
  logic [CNT_W-1:0] db_cnt_s [4];
  logic [CNT_W-1:0] db_inc_s [4];
  logic [3:0]       rise_s;

  state_t     state_r, state_s;
  logic [2:0] dir_out_r, dir_out_s;
  logic       dir_valid_r, dir_valid_s;
  logic       multi_err_r, multi_err_s;
  logic       btn_busy_r, btn_busy_s;
  logic [7:0] press_count_r, press_count_s;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt_r, rep_cnt_s, rep_inc_s;
  logic [3:0]       rep_mask_r, rep_mask_s;
  logic             rep_armed_r, rep_armed_s;

  assign rep_inc_s = rep_cnt_r + REP_W'(1);
`endif

  // Two-stage synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounce next-state: a level flips only after DEBOUNCE_CYCLES straight disagreements
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_inc_s[i] = db_cnt_r[i] + CNT_W'(1);
      stable_s[i] = stable_r[i];
      db_cnt_s[i] = {CNT_W{1'b0}};
      if (sync2_r[i] != stable_r[i]) begin
        if (db_inc_s[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          stable_s[i] = ~stable_r[i];
          db_cnt_s[i] = {CNT_W{1'b0}};
        end else begin
          stable_s[i] = stable_r[i];
          db_cnt_s[i] = db_inc_s[i];
        end
      end else begin
        stable_s[i] = stable_r[i];
        db_cnt_s[i] = {CNT_W{1'b0}};
      end
    end
  end

  // Debounce state and the one-cycle delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r   <= 4'b0000;
      stable_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      stable_r   <= stable_s;
      stable_d_r <= stable_r;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= db_cnt_s[i];
      end
    end
  end

  assign rise_s = stable_r & ~stable_d_r;

  // Press decode FSM: next state and next output values
  always_comb begin
    state_s       = state_r;
    dir_out_s     = dir_out_r;
    dir_valid_s   = 1'b0;
    multi_err_s   = 1'b0;
    press_count_s = press_count_r;
    btn_busy_s    = |stable_r;
`ifdef AUTO_REPEAT_EN
    rep_cnt_s     = rep_cnt_r;
    rep_mask_s    = rep_mask_r;
    rep_armed_s   = rep_armed_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rise_s != 4'b0000) begin
          // Any rise with a single stable bit means that bit is the only one pressed
          if (popcount4(stable_r) == 3'd1) begin
            dir_valid_s   = 1'b1;
            dir_out_s     = encode_dir(stable_r);
            press_count_s = press_count_r + 8'd1;
`ifdef AUTO_REPEAT_EN
            rep_mask_s    = stable_r;
            rep_armed_s   = 1'b1;
`endif
          end else begin
            multi_err_s   = 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_mask_s    = 4'b0000;
            rep_armed_s   = 1'b0;
`endif
          end
`ifdef AUTO_REPEAT_EN
          rep_cnt_s = {REP_W{1'b0}};
`endif
          state_s = ST_HELD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (stable_r == 4'b0000) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HELD;
`ifdef AUTO_REPEAT_EN
          if (stable_r != stable_d_r) begin
            rep_cnt_s = {REP_W{1'b0}};
          end else if (rep_armed_r && (stable_r == rep_mask_r)) begin
            if (rep_inc_s == REP_W'(REPEAT_CYCLES)) begin
              dir_valid_s   = 1'b1;
              press_count_s = press_count_r + 8'd1;
              rep_cnt_s     = {REP_W{1'b0}};
            end else begin
              rep_cnt_s = rep_inc_s;
            end
          end else begin
            rep_cnt_s = {REP_W{1'b0}};
          end
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      dir_out_r     <= 3'b111;
      dir_valid_r   <= 1'b0;
      multi_err_r   <= 1'b0;
      btn_busy_r    <= 1'b0;
      press_count_r <= 8'd0;
    end else begin
      state_r       <= state_s;
      dir_out_r     <= dir_out_s;
      dir_valid_r   <= dir_valid_s;
      multi_err_r   <= multi_err_s;
      btn_busy_r    <= btn_busy_s;
      press_count_r <= press_count_s;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Auto-repeat tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_r   <= {REP_W{1'b0}};
      rep_mask_r  <= 4'b0000;
      rep_armed_r <= 1'b0;
    end else begin
      rep_cnt_r   <= rep_cnt_s;
      rep_mask_r  <= rep_mask_s;
      rep_armed_r <= rep_armed_s;
    end
  end
`endif

  assign dir_out     = dir_out_r;
  assign dir_valid   = dir_valid_r;
  assign multi_err   = multi_err_r;
  assign btn_busy    = btn_busy_r;
  assign press_count = press_count_r;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Self-checking bench for dir_input_conditioner: a press-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_dir_input_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [2:0] dir_out;
  logic       dir_valid;
  logic       multi_err;
  logic       btn_busy;
  logic [7:0] press_count;

  always #5 clk = ~clk;

  dir_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(16),
    .REPEAT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .dir_out(dir_out),
    .dir_valid(dir_valid),
    .multi_err(multi_err),
    .btn_busy(btn_busy),
    .press_count(press_count)
  );

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_merr = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [3:0] m_s1, m_s2, m_stable, m_prev;
  int         m_run [4];
  bit         m_locked;
  logic [2:0] e_dir;
  logic       e_valid, e_merr, e_busy;
  logic [7:0] e_cnt;

  logic [3:0] seq_raw  [5] = '{4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b0001};
  logic [2:0] seq_code [5] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] code_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 3'(i);
    end
    return 3'b111;
  endfunction

  // One clock of the reference model, using the inputs present at the edge.
  task automatic model_step();
    logic [3:0] rises;
    if (reset) begin
      m_s1 = 4'b0000; m_s2 = 4'b0000; m_stable = 4'b0000; m_prev = 4'b0000;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_locked = 1'b0;
      e_dir = 3'b111; e_valid = 1'b0; e_merr = 1'b0; e_busy = 1'b0; e_cnt = 8'd0;
    end else begin
      rises   = m_stable & ~m_prev;
      e_valid = 1'b0;
      e_merr  = 1'b0;
      if (!m_locked) begin
        if (rises != 4'b0000) begin
          if ($countones(m_stable) == 1) begin
            e_valid = 1'b1;
            e_dir   = code_of(m_stable);
            e_cnt   = e_cnt + 8'd1;
          end else begin
            e_merr = 1'b1;
          end
          m_locked = 1'b1;
        end
      end else if (m_stable == 4'b0000) begin
        m_locked = 1'b0;
      end
      e_busy = |m_stable;
      m_prev = m_stable;
      // a level flips after DB consecutive synchronised samples that disagree with it
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_stable[i] = ~m_stable[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    btn_raw = raw;
    repeat (n) tick();
  endtask

  // Compare process: DUT against the model on every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dir_out", 32'(dir_out), 32'(e_dir));
      check("dir_valid", 32'(dir_valid), 32'(e_valid));
      check("multi_err", 32'(multi_err), 32'(e_merr));
      check("btn_busy", 32'(btn_busy), 32'(e_busy));
      check("press_count", 32'(press_count), 32'(e_cnt));
      if (dir_valid === 1'b1) n_valid++;
      if (multi_err === 1'b1) n_merr++;
    end
  end

  initial begin
    int vedge;
    int bedge;
    reset   = 1'b1;
    btn_raw = 4'b0000;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_dir_out", 32'(dir_out), 32'd7);
    check("rst_press_count", 32'(press_count), 32'd0);
    check("rst_btn_busy", 32'(btn_busy), 32'd0);
    reset = 1'b0;

    // glitch shorter than the debounce window
    hold(4'b1000, 3);
    hold(4'b0000, 15);
    check("glitch_pulses", n_valid, 0);
    check("glitch_dir_out", 32'(dir_out), 32'd7);
    check("glitch_count", 32'(press_count), 32'd0);

    // clean UP press: pulse after edge DB+3
    btn_raw = 4'b0001;
    vedge = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (dir_valid === 1'b1 && vedge == 0) vedge = k;
    end
    check("press_latency", vedge, DB + 3);
    check("press_pulses", n_valid, 1);
    check("press_dir_out", 32'(dir_out), 32'd0);
    check("press_count1", 32'(press_count), 32'd1);
    check("press_busy", 32'(btn_busy), 32'd1);

    btn_raw = 4'b0000;
    bedge = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_busy === 1'b0 && bedge == 0) bedge = k;
    end
    check("release_busy_edge", bedge, 2 + DB + 1);
    check("release_pulses", n_valid, 1);

    // chord
    hold(4'b0110, 10);
    hold(4'b0000, 15);
    check("chord_merr", n_merr, 1);
    check("chord_pulses", n_valid, 1);
    check("chord_dir_out", 32'(dir_out), 32'd0);

    // direction sequence
    for (int i = 0; i < 5; i++) begin
      hold(seq_raw[i], 10);
      check("seq_dir_out", 32'(dir_out), 32'(seq_code[i]));
      hold(4'b0000, 10);
    end
    check("seq_pulses", n_valid, 6);
    check("seq_count", 32'(press_count), 32'd6);

    // press while another is held
    hold(4'b0001, 10);
    hold(4'b0101, 10);
    hold(4'b0000, 15);
    check("held_pulses", n_valid, 7);
    check("held_dir_out", 32'(dir_out), 32'd0);
    check("held_merr", n_merr, 1);
    hold(4'b0100, 10);
    check("fresh_left_dir", 32'(dir_out), 32'd2);
    check("fresh_left_pulses", n_valid, 8);
    hold(4'b0000, 15);
    check("fresh_left_count", 32'(press_count), 32'd8);

    // reset in the middle of a debounce
    hold(4'b0010, 4);
    reset   = 1'b1;
    btn_raw = 4'b0000;
    tick();
    tick();
    check("midrst_dir_out", 32'(dir_out), 32'd7);
    check("midrst_count", 32'(press_count), 32'd0);
    check("midrst_busy", 32'(btn_busy), 32'd0);
    reset = 1'b0;
    hold(4'b0000, 15);
    check("midrst_pulses", n_valid, 8);
    check("midrst_dir_after", 32'(dir_out), 32'd7);

    // 256 accepted presses wrap the counter
    for (int i = 0; i < 256; i++) begin
      hold(4'b0001, 8);
      hold(4'b0000, 8);
    end
    check("wrap_count", 32'(press_count), 32'd0);
    check("wrap_pulses", n_valid, 264);
    check("wrap_dir_out", 32'(dir_out), 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
